// File: rtl/crank_position_control_pkg.sv
// crank_position_control_pkg
//   Shared configuration for the crank position tracker.
//   CFG_NUM_TEETH           : default teeth per revolution (even, >= 4)
//   CFG_CYCLE_COUNTER_WIDTH : default width of the tooth-period counter
//   HALF_TEETH              : tooth index of the half-revolution tick
package crank_position_control_pkg;

  localparam int CFG_NUM_TEETH           = 60;
  localparam int CFG_CYCLE_COUNTER_WIDTH = 32;

  // Half-revolution index for an arbitrary tooth count.
  function automatic int half_teeth(input int n);
    return n / 2;
  endfunction

  localparam int HALF_TEETH = half_teeth(CFG_NUM_TEETH);

endpackage

// File: rtl/crank_position_control_ckp_edge_detect.sv
// ckp_edge_detect
//   Brings the asynchronous CKP level into the clk domain and produces a
//   one-cycle pulse on each rising edge. The edge detector always runs, even
//   while the consuming block is disabled.
//   Optional macro HUST_EFI_CKP_GLITCH_FILTER_EN inserts a stability filter
//   that only follows the input after FILTER_CYCLES consecutive equal samples.
// Ports:
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   ckp     in  raw CKP level, asynchronous to clk
//   tooth   out rising-edge pulse (combinational from registered state)
module ckp_edge_detect #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ckp,
  output logic tooth
);

`ifdef HUST_EFI_CKP_GLITCH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic ckp_p0;
  logic ckp_p1;
  logic level;
  logic level_prev;

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ckp_p0 <= 1'b0;
      ckp_p1 <= 1'b0;
    end else begin
      ckp_p0 <= ckp;
      ckp_p1 <= ckp_p0;
    end
  end

  if (FILTER_EN && FILTER_CYCLES >= 1) begin : g_filter
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    logic [FW-1:0] stab_cnt;
    logic          filt;

    // Stage filter: output flips only after FILTER_CYCLES differing samples
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stab_cnt <= '0;
        filt     <= 1'b0;
      end else if (ckp_p1 == filt) begin
        stab_cnt <= '0;
      end else if (stab_cnt == FW'(FILTER_CYCLES - 1)) begin
        stab_cnt <= '0;
        filt     <= ckp_p1;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end

    assign level = filt;
  end else begin : g_nofilter
    assign level = ckp_p1;
  end

  // Stage prev: previous level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_prev <= 1'b0;
    else          level_prev <= level;
  end

  assign tooth = level & ~level_prev;

endmodule

// File: rtl/crank_position_control.sv
// crank_position_control
//   Tracks crankshaft position from CKP teeth: tooth index modulo NUM_TEETH,
//   tooth period in clk cycles, and strobes for downstream RPM/BTDC math.
//   Optional macro HUST_EFI_CKP_GLITCH_FILTER_EN adds a CKP glitch filter
//   (FILTER_CYCLES long) inside the edge detector.
// Ports:
//   clk                 in  125 MHz system clock
//   reset_n             in  asynchronous active-low reset
//   ckp                 in  raw CKP level (asynchronous)
//   on                  in  enable; 0 clears counters and pulses
//   crank_tick          out pulse when counter becomes NUM_TEETH/2 or 0
//   crank_counter       out current tooth index
//   crank_cycle_counter out period of the last complete tooth (saturating)
//   crank_changed       out pulse on every counter update
//   cal_rpm             out RPM calculation strobe
//   cal_btdc            out BTDC calculation strobe
module crank_position_control
  import crank_position_control_pkg::*;
#(
  parameter int NUM_TEETH           = CFG_NUM_TEETH,
  parameter int CYCLE_COUNTER_WIDTH = CFG_CYCLE_COUNTER_WIDTH,
  parameter int FILTER_CYCLES       = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ckp,
  input  logic                           on,
  output logic                           crank_tick,
  output logic [$clog2(NUM_TEETH)-1:0]   crank_counter,
  output logic [CYCLE_COUNTER_WIDTH-1:0] crank_cycle_counter,
  output logic                           crank_changed,
  output logic                           cal_rpm,
  output logic                           cal_btdc
);

  localparam int CNT_W = $clog2(NUM_TEETH);
  localparam logic [CNT_W-1:0] LAST_TOOTH = CNT_W'(NUM_TEETH - 1);
  localparam logic [CNT_W-1:0] HALF_TOOTH = CNT_W'(half_teeth(NUM_TEETH));

  // Saturating increment: a stalled engine pins the period at all-ones.
  function automatic logic [CYCLE_COUNTER_WIDTH-1:0] sat_inc(
    input logic [CYCLE_COUNTER_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                           tooth;
  logic [CNT_W-1:0]               cnt_next;
  logic                           tick_next;
  logic [CYCLE_COUNTER_WIDTH-1:0] period_cnt;
  logic                           first;

  ckp_edge_detect #(
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .ckp     (ckp),
    .tooth   (tooth)
  );

  always_comb begin
    cnt_next  = (crank_counter == LAST_TOOTH) ? '0 : crank_counter + 1'b1;
    tick_next = (cnt_next == HALF_TOOTH) || (cnt_next == '0);
  end

  // Stage out: counting, period latch and strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crank_counter       <= '0;
      crank_cycle_counter <= '0;
      period_cnt          <= '0;
      crank_tick          <= 1'b0;
      crank_changed       <= 1'b0;
      cal_rpm             <= 1'b0;
      cal_btdc            <= 1'b0;
      first               <= 1'b1;
    end else if (!on) begin
      crank_counter       <= '0;
      crank_cycle_counter <= '0;
      period_cnt          <= '0;
      crank_tick          <= 1'b0;
      crank_changed       <= 1'b0;
      cal_rpm             <= 1'b0;
      cal_btdc            <= 1'b0;
      first               <= 1'b1;
    end else begin
      crank_tick    <= 1'b0;
      crank_changed <= 1'b0;
      cal_rpm       <= 1'b0;
      cal_btdc      <= 1'b0;
      period_cnt    <= sat_inc(period_cnt);
      if (tooth) begin
        crank_counter <= cnt_next;
        crank_changed <= 1'b1;
        crank_tick    <= tick_next;
        cal_rpm       <= tick_next;
        // The first tooth after enabling has no valid start point to measure.
        if (!first) begin
          crank_cycle_counter <= sat_inc(period_cnt);
          cal_btdc            <= 1'b1;
        end else begin
          first <= 1'b0;
        end
        period_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_crank_position_control.sv
module tb_crank_position_control;

  localparam int NT = 60;
  localparam int CW = 8;
`ifdef HUST_EFI_CKP_GLITCH_FILTER_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ckp;
  logic          on;
  logic          crank_tick;
  logic [5:0]    crank_counter;
  logic [CW-1:0] crank_cycle_counter;
  logic          crank_changed;
  logic          cal_rpm;
  logic          cal_btdc;

  int n_checks = 0;
  int n_errors = 0;

  crank_position_control #(
    .NUM_TEETH           (NT),
    .CYCLE_COUNTER_WIDTH (CW),
    .FILTER_CYCLES       (8)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .ckp                 (ckp),
    .on                  (on),
    .crank_tick          (crank_tick),
    .crank_counter       (crank_counter),
    .crank_cycle_counter (crank_cycle_counter),
    .crank_changed       (crank_changed),
    .cal_rpm             (cal_rpm),
    .cal_btdc            (cal_btdc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rising ckp edge; checks the pulse cycle and the cycle after it.
  task automatic do_edge(input int exp_cnt, input bit exp_btdc, input int exp_ccc);
    bit exp_tick;
    exp_tick = (exp_cnt == 30) || (exp_cnt == 0);
    @(negedge clk) ckp = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    check("changed", 32'(crank_changed), 1);
    check("counter", 32'(crank_counter), exp_cnt);
    check("tick", 32'(crank_tick), 32'(exp_tick));
    check("rpm", 32'(cal_rpm), 32'(exp_tick));
    check("btdc", 32'(cal_btdc), 32'(exp_btdc));
    check("cycles", 32'(crank_cycle_counter), exp_ccc);
    @(posedge clk);
    #1;
    check("changed_off", 32'(crank_changed), 0);
    check("tick_off", 32'(crank_tick), 0);
    check("btdc_off", 32'(cal_btdc), 0);
    @(negedge clk) ckp = 1'b0;
  endtask

  // Pads so consecutive rising edges are 'period' cycles apart.
  task automatic gap(input int period);
    repeat (period - (LAT + 2)) @(negedge clk);
  endtask

  initial begin
    int cycles;
    bit seen;
    reset_n = 1'b0;
    ckp     = 1'b0;
    on      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_counter", 32'(crank_counter), 0);
    check("rst_cycles", 32'(crank_cycle_counter), 0);
    check("rst_pulses", {26'd0, crank_tick, crank_changed, cal_rpm, cal_btdc}, 0);
    @(negedge clk) reset_n = 1'b1;

    // ckp already high when enabled: no tooth
    @(negedge clk) ckp = 1'b1;
    repeat (15) @(negedge clk);
    on = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("pre_high_changed", 32'(crank_changed), 0);
      check("pre_high_counter", 32'(crank_counter), 0);
    end
    @(negedge clk) ckp = 1'b0;
    repeat (15) @(negedge clk);

    // first three teeth, 100 cycles apart
    do_edge(1, 1'b0, 0);
    gap(100);
    do_edge(2, 1'b1, 100);
    gap(100);
    do_edge(3, 1'b1, 100);

    // through half revolution and wrap
    for (int i = 4; i <= 60; i++) begin
      gap(20);
      do_edge(i % 60, 1'b1, 20);
    end

    // disable mid-revolution at tooth 17
    for (int i = 1; i <= 17; i++) begin
      gap(20);
      do_edge(i, 1'b1, 20);
    end
    @(negedge clk) on = 1'b0;
    @(posedge clk);
    #1;
    check("off_counter", 32'(crank_counter), 0);
    check("off_cycles", 32'(crank_cycle_counter), 0);
    check("off_pulses", {26'd0, crank_tick, crank_changed, cal_rpm, cal_btdc}, 0);
    @(negedge clk) ckp = 1'b1;
    seen = 1'b0;
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      seen |= crank_changed | crank_tick | cal_btdc;
    end
    check("off_edge_pulse", 32'(seen), 0);
    check("off_edge_counter", 32'(crank_counter), 0);
    @(negedge clk) ckp = 1'b0;
    repeat (15) @(negedge clk);

    // stall: period saturates at 255
    on = 1'b1;
    do_edge(1, 1'b0, 0);
    repeat (300) @(negedge clk);
    do_edge(2, 1'b1, 255);

    // latency from ckp sample to outputs
    repeat (20) @(negedge clk);
    @(negedge clk) ckp = 1'b1;
    cycles = 0;
    while (!crank_changed && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("latency", cycles, LAT);
    check("latency_counter", 32'(crank_counter), 3);
    repeat (20) @(negedge clk);
    ckp = 1'b0;
    repeat (20) @(negedge clk);

`ifdef HUST_EFI_CKP_GLITCH_FILTER_EN
    // short glitch is rejected
    ckp = 1'b1;
    repeat (3) @(negedge clk);
    ckp = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen |= crank_changed;
    end
    check("glitch_pulse", 32'(seen), 0);
    check("glitch_counter", 32'(crank_counter), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/crank_position_control.md
Name: crank_position_control

Overview:
- Tracks crankshaft angular position from the CKP (crank position sensor) tooth signal in the engine-control datapath.
- Counts teeth modulo NUM_TEETH and measures the tooth period in clk cycles.
- Emits strobes that tell the downstream RPM and BTDC (before-top-dead-centre) calculators when new data is valid.
- Runs at 125 MHz; gated by an enable input `on`.

Parameters:
- NUM_TEETH, default 60 (global CFG_NUM_TEETH): teeth per revolution; must be even and ≥4.
- CYCLE_COUNTER_WIDTH, default 32 (global CFG_CYCLE_COUNTER_WIDTH): width of the tooth-period counter.
- FILTER_CYCLES, default 8: glitch-filter stability length; used only with the optional feature.

Ports:
- clk  in  1  system clock, 125 MHz
- reset_n  in  1  asynchronous active-low reset
- ckp  in  1  raw CKP sensor level, asynchronous to clk
- on  in  1  block enable; 0 = idle and cleared
- crank_tick  out  1  1-cycle pulse when the new crank_counter equals NUM_TEETH/2 or wraps to 0
- crank_counter  out  $clog2(NUM_TEETH)  current tooth index, 0..NUM_TEETH-1
- crank_cycle_counter  out  CYCLE_COUNTER_WIDTH  latched clk-cycle length of the last complete tooth period
- crank_changed  out  1  1-cycle pulse whenever crank_counter updates
- cal_rpm  out  1  1-cycle strobe permitting RPM calculation
- cal_btdc  out  1  1-cycle strobe permitting BTDC calculation

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs, counters and synchronizer flops go to 0. The synchronizer and previous-sample flops reset to 0.
- ckp passes through a 2-flop synchronizer, then a registered previous-sample flop. A tooth event is sync=1 while prev=0, i.e. a rising edge.
- The edge detector always runs, even with on=0. Asserting `on` while ckp is already high therefore causes no spurious tooth.
- on=0: crank_counter, the internal period counter, crank_cycle_counter and all pulses are forced to 0 synchronously. A `first` flag is set to 1.
- on=1, internal period counter:
  - Increments every clk.
  - Saturates at all-ones; no wrap, which gives stall detection.
- on=1, on a tooth event, all of the following register on the same clk edge:
  - crank_counter <= (crank_counter == NUM_TEETH-1) ? 0 : crank_counter+1.
  - crank_changed = 1 for one cycle.
  - crank_tick = 1 for one cycle if the new value is NUM_TEETH/2 or 0.
  - cal_rpm = crank_tick.
  - If first=0: crank_cycle_counter <= internal count + 1 (the count includes the event cycle), and cal_btdc = 1 for one cycle.
  - If first=1: no latch, cal_btdc stays 0, and first is cleared.
  - The internal counter restarts at 0.
- Latency: ckp high sampled at clk edge N gives registered outputs at edge N+2. The pulses are high during the cycle following edge N+2.
- Back-to-back tooth events: must be separated by at least 2 cycles. Each event still produces its own pulse.
- Outputs are fully registered.

Optional Feature:
- Macro HUST_EFI_CKP_GLITCH_FILTER_EN.
- Defined: the synchronized ckp feeds a filter. The filter's output changes only after the input has held a new level for FILTER_CYCLES consecutive clks. Edge detection uses the filtered level, so latency grows by FILTER_CYCLES. Filter state resets to 0.
- Undefined: no filter; latency is as stated above.

Decomposition:
- The shared defines/package provides CFG_NUM_TEETH and CFG_CYCLE_COUNTER_WIDTH, plus the derived constant HALF_TEETH = NUM_TEETH/2.
- One sub-module, ckp_edge_detect: synchronizer, the optional filter and the rising-edge pulse.
- Counting and strobes stay in the top level.

Test Plan:
- Reset, then on=1, then 3 ckp rising edges 100 cycles apart → crank_counter goes 1,2,3, each with a crank_changed pulse. First edge: no cal_btdc. Edges 2 and 3: cal_btdc with crank_cycle_counter = 100.
- 30 edges from counter 0 (NUM_TEETH=60) → crank_tick and cal_rpm pulse exactly when crank_counter becomes 30. 60 edges → the counter wraps to 0 with crank_tick.
- Drive ckp high before on=1, then assert on → no tooth event and crank_counter stays 0 until the next rising edge.
- on drops from 1 to 0 mid-revolution at counter 17 → next cycle the counter and crank_cycle_counter are 0 and no pulses occur. Ticking during on=0 still gives counter 0.
- No edges for 2^CYCLE_COUNTER_WIDTH cycles (use width 8 in the bench) then an edge → crank_cycle_counter = 255 (saturated).
- With HUST_EFI_CKP_GLITCH_FILTER_EN and FILTER_CYCLES=8: a 3-cycle ckp pulse → no event. A 20-cycle pulse → one event, 8 cycles later than in the unfiltered build.
